// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from a standard (non-FWFT) FIFO and sends each as an 8N1/8N2 UART frame.
// Status outputs feed debug LEDs and the message loader's pacing.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        tx_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);
    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : gBadParams
            $error("uart_tx_serializer: illegal CLKS_PER_BIT or STOP_BITS");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} stateType;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    stateType    state;
    logic [15:0] baudCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shiftReg;
    logic        bitEnd;

    assign bitEnd = baudCnt == LAST_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            baudCnt     <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            tx_data     <= 1'b1;
            fifo_rd_en  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            baudCnt    <= (state inside {START, DATA, STOP} && !bitEnd) ? baudCnt + 16'd1 : 16'd0;
            case (state)
                IDLE: if (!fifo_empty) begin
                    state      <= FETCH;
                    fifo_rd_en <= 1'b1;
                    busy       <= 1'b1;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    shiftReg <= fifo_dout;
                    tx_data  <= 1'b0;
                    state    <= START;
                end
                START: if (bitEnd) begin
                    tx_data  <= shiftReg[0];
                    shiftReg <= shiftReg >> 1;
                    state    <= DATA;
                end
                DATA: if (bitEnd) begin
                    // bitIdx wraps 7->0 here so STOP can reuse it to count stop bits
                    bitIdx   <= bitIdx + 3'd1;
                    tx_data  <= bitIdx == 3'd7 ? 1'b1 : shiftReg[0];
                    shiftReg <= shiftReg >> 1;
                    if (bitIdx == 3'd7) state <= STOP;
                end
                STOP: if (bitEnd) begin
                    bitIdx <= bitIdx == LAST_STOP ? 3'd0 : bitIdx + 3'd1;
                    if (bitIdx == LAST_STOP) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: two serializers (1 and 2 stop bits) fed from FIFO models; every line cycle is
// compared against the frame expected from the byte that was popped.
module tb_uart_tx_serializer;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         nCompared = 0;
    int         nMismatched = 0;
    logic [7:0] mem [2][1024];
    int         pushed [2] = '{0, 0};
    int         sentOffset [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pushByte(input int l, input logic [7:0] b);
        @(posedge clk);
        #1;
        mem[l][pushed[l]] = b;
        pushed[l]++;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int FL = (10 + g) * CPB;
        logic        fifoEmpty, rdEn, tx, busy, done;
        logic [7:0]  dout = 8'h00;
        logic [15:0] sent;
        int popped = 0, pops = 0, starts = 0, dones = 0, decoded = 0, sinceRst = 0;
        int t0 = 0, lastRd = -100, expectNext = -1, k = 0;
        bit inFrame = 0, prevTx = 1, prevEmpty = 1, prevRd = 0, prevDone = 0;
        logic [7:0] cur = 8'h00;
        logic       expBit;

        assign fifoEmpty = pushed[g] == popped;

        uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(g + 1)) dut (
            .clk(clk), .rst(rst), .fifo_empty(fifoEmpty), .fifo_dout(dout),
            .fifo_rd_en(rdEn), .tx_data(tx), .busy(busy), .frame_done(done), .frames_sent(sent)
        );

        always @(posedge clk) if (rdEn && !fifoEmpty) begin
            dout   <= mem[g][popped];
            popped <= popped + 1;
        end

        always @(negedge clk) begin
            if (rst) begin
                inFrame = 0; expectNext = -1; sinceRst = 0; lastRd = -100;
            end else begin
                if (rdEn) begin
                    checkVal("pop_when_empty", 32'(prevEmpty), 0);
                    checkVal("double_pop", 32'(prevRd), 0);
                    checkVal("busy_fetch", 32'(busy), 1);
                    cur = mem[g][popped]; lastRd = cyc; pops++;
                end
                if (!inFrame && prevTx && !tx) begin
                    inFrame = 1; t0 = cyc; starts++;
                    checkVal("start_latency", cyc - lastRd, 2);
                    if (expectNext >= 0) checkVal("start_gap", cyc, expectNext);
                    expectNext = -1;
                end else if (!inFrame) checkVal("mark_idle", 32'(tx), 1);
                if (inFrame) begin
                    k = cyc - t0;
                    if (k < FL) begin
                        expBit = k < CPB ? 1'b0 : k < 9 * CPB ? cur[3'(k / CPB - 1)] : 1'b1;
                        checkVal("tx_bit", 32'(tx), 32'(expBit));
                        checkVal("busy_frame", 32'(busy), 1);
                        checkVal("done_early", 32'(done), 0);
                    end else begin
                        checkVal("done_pulse", 32'(done), 1);
                        checkVal("busy_clear", 32'(busy), 0);
                        checkVal("tx_after_stop", 32'(tx), 1);
                        decoded++; sinceRst++;
                        checkVal("frames_sent", 32'(sent), 32'(16'(sinceRst + sentOffset[g])));
                        inFrame = 0;
                        if (!fifoEmpty) expectNext = cyc + 3;
                    end
                end
                if (done) begin
                    dones++;
                    checkVal("done_width", 32'(prevDone), 0);
                end
            end
            prevTx = tx; prevEmpty = fifoEmpty; prevRd = rdEn; prevDone = done;
        end
    end

    task automatic drain();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (lane[0].fifoEmpty && lane[1].fifoEmpty && !lane[0].busy && !lane[1].busy) break;
        end
        repeat (2) @(negedge clk);
        checkVal("drain", 32'({lane[0].fifoEmpty, lane[1].fifoEmpty, lane[0].busy, lane[1].busy}), 'b1100);
    endtask

    int startsBefore, donesBefore;

    initial begin
        repeat (3) @(negedge clk);
        checkVal("rst_lines0", 32'({lane[0].tx, lane[0].rdEn, lane[0].busy, lane[0].done}), 'b1000);
        checkVal("rst_lines1", 32'({lane[1].tx, lane[1].rdEn, lane[1].busy, lane[1].done}), 'b1000);
        checkVal("rst_sent0", 32'(lane[0].sent), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        pushByte(0, 8'h55);
        drain();
        checkVal("t1_sent", 32'(lane[0].sent), 1);
        checkVal("t1_pops", lane[0].pops, 1);
        checkVal("t1_dones", lane[0].dones, 1);

        pushByte(0, 8'h44);
        pushByte(0, 8'h69);
        drain();
        checkVal("t2_sent", 32'(lane[0].sent), 3);
        checkVal("t2_pops", lane[0].pops, 3);

        pushByte(1, 8'hFF);
        drain();
        checkVal("t4_sent", 32'(lane[1].sent), 1);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            checkVal("t3_idle", 32'({lane[0].rdEn, lane[0].busy, lane[0].done, lane[0].tx}), 1);
        end

        for (int i = 0; i < 40; i++) begin
            pushByte(int'($urandom_range(1, 0)), 8'($urandom));
            repeat ($urandom_range(60, 0)) @(posedge clk);
        end
        drain();
        checkVal("rand_sent0", 32'(lane[0].sent), pushed[0]);
        checkVal("rand_sent1", 32'(lane[1].sent), pushed[1]);

        // reset in the middle of the third data bit of 0x00
        pushByte(0, 8'h00);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (lane[0].inFrame && cyc - lane[0].t0 == 3 * CPB + 1) break;
        end
        checkVal("t5_pre_tx", 32'(lane[0].tx), 0);
        rst = 1'b1;
        #1;
        checkVal("t5_async", 32'({lane[0].tx, lane[0].rdEn, lane[0].busy, lane[0].done}), 'b1000);
        checkVal("t5_sent", 32'(lane[0].sent), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        startsBefore = lane[0].starts;
        repeat (100) @(negedge clk);
        checkVal("t5_no_restart", lane[0].starts, startsBefore);
        checkVal("t5_idle", 32'({lane[0].busy, lane[0].tx}), 'b01);

        sentOffset[0] = 65535;
        @(posedge clk);
        #1 force lane[0].dut.frames_sent = 16'hFFFF;
        @(posedge clk);
        #1 release lane[0].dut.frames_sent;
        @(negedge clk);
        checkVal("t6_forced", 32'(lane[0].sent), 'hFFFF);
        donesBefore = lane[0].dones;
        pushByte(0, 8'hA5);
        drain();
        checkVal("t6_wrap", 32'(lane[0].sent), 0);
        checkVal("t6_done", lane[0].dones - donesBefore, 1);

        checkVal("pops0", lane[0].pops, pushed[0]);
        checkVal("pops1", lane[1].pops, pushed[1]);
        checkVal("decoded0", lane[0].decoded, pushed[0] - 1);
        checkVal("decoded1", lane[1].decoded, pushed[1]);
        checkVal("dones0", lane[0].dones, lane[0].decoded);
        checkVal("dones1", lane[1].dones, lane[1].decoded);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Downstream stage of the telemetry UART message loader. Pops bytes one at a time from the loader's 8-bit byte FIFO and serializes each as an 8N1 (or 8N2) frame on the tx_data line at a fixed baud. Runs in the same clk domain as the FIFO read side. Also provides busy, frame-done and frame-count status for debug LEDs and the loader's pacing.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock; also the FIFO read clock
rst  in  1  reset
fifo_empty  in  1  FIFO empty flag, high = no byte available
fifo_dout  in  8  FIFO read data; valid the cycle after a cycle with fifo_rd_en=1 (standard, non-FWFT FIFO)
fifo_rd_en  out  1  FIFO pop strobe, single-cycle pulse per byte
tx_data  out  1  serial line, idle/mark = 1
busy  out  1  high whenever a byte is being fetched or a frame is on the line
frame_done  out  1  one-cycle pulse after the last stop bit of each frame
frames_sent  out  16  count of completed frames, wraps 65535->0

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is updated on the posedge of clk.
- Reset values: tx_data=1, fifo_rd_en=0, busy=0, frame_done=0, frames_sent=0, state=IDLE, baud counter=0, bit index=0.
- All outputs are registered. busy = (state != IDLE).
- FSM states: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE transition: if fifo_empty=0 is sampled in IDLE, go to FETCH. The FETCH cycle drives fifo_rd_en=1; this is the only state that asserts it. Otherwise stay in IDLE with tx_data=1.
- FETCH: after one cycle, go to LATCH.
- LATCH: capture fifo_dout into the shift register, go to START, and drive tx_data to 0 on the same edge.
- START: tx_data=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
- STOP: tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Latency: the first IDLE cycle that samples fifo_empty=0 is followed by the tx_data falling edge 3 clk edges later.
- Frame length on the line is (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Frame completion: on the edge ending the last stop cycle, the FSM enters IDLE. frame_done=1 for exactly that first IDLE cycle, and frames_sent increments on the same edge.
- Back-to-back frames: start edge to start edge is (9+STOP_BITS)*CLKS_PER_BIT+3 cycles. The extra 3 cycles are mark (tx_data=1).
- The baud counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. It is wide enough for 65535.
- fifo_empty and fifo_dout are ignored outside IDLE and LATCH. A FIFO going empty or full mid-frame has no effect on the frame in progress.
- fifo_rd_en is never asserted unless fifo_empty was 0 in the preceding cycle. There is exactly one pop per frame, with no double pops and no pops on empty.
- Reset mid-frame: tx_data returns to 1 immediately and asynchronously. The byte in flight is discarded, not re-read, and frames_sent clears.
- Reset asserted during FETCH: the pop already taken by the FIFO is lost. This is accepted behaviour; the loader resets with the same rst.
- frames_sent wraps from 65535 to 0 without saturation. frame_done still pulses on the wrapping frame.
- Illegal parameters (CLKS_PER_BIT<2, STOP_BITS not 1 or 2) are rejected at elaboration time.

Test Plan:
1. CLKS_PER_BIT=4, STOP_BITS=1; FIFO holds 0x55 -> exactly one fifo_rd_en pulse; tx_data waveform is 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level held 4 cycles; frame_done pulses one cycle after the 40 frame cycles; frames_sent=1; busy falls the same cycle frame_done rises.
2. FIFO preloaded with 0x44 ("D") and 0x69 ("i"), CLKS_PER_BIT=4 -> two frames; start edges 43 cycles apart with 3 mark cycles between them; decoded bytes are 0x44 then 0x69; FIFO empty afterwards; frames_sent=2.
3. fifo_empty held at 1 for 1000 cycles -> fifo_rd_en never asserted; tx_data=1, busy=0, frame_done=0 throughout.
4. STOP_BITS=2, CLKS_PER_BIT=4, byte 0xFF -> 4-cycle start low, then 32+8 cycles high; frame_done lands 44 cycles after the start edge.
5. rst pulsed at the 3rd data bit of 0x00 -> tx_data=1 within the same cycle; all outputs at reset values; after release with FIFO empty, no new frame starts.
6. Force frames_sent to 65535 (or send 65536 frames with CLKS_PER_BIT=2), then send one more frame -> frames_sent=0 and frame_done pulses once.
